// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding for the serial arithmetic blocks
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit full subtractor cell, d = a - b - bin
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock with start/done handshake
module serial_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nx, d_msb;
    logic [CW-1:0]    cnt;
    logic             br, br_nx, d, a_msb, b_msb, accept, last;

    full_subtractor u_fs (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (br),
        .d   (d),
        .bout(br_nx)
    );

    assign ready  = state == ST_IDLE;
    assign busy   = state == ST_BUSY;
    assign done   = state == ST_DONE;
    assign accept = ready && start;
    assign last   = busy && cnt == CW'(WIDTH - 1);

    // next state; DONE and the unused encoding both fall back to IDLE
    always_comb begin
        state_nx = ready ? (start ? ST_BUSY : ST_IDLE) :
                   busy  ? (last ? ST_DONE : ST_BUSY) : ST_IDLE;
    end

    // place the new difference bit at the MSB of the result shifter
    always_comb begin
        d_msb           = '0;
        d_msb[WIDTH-1]  = d;
        r_nx            = (r_sr >> 1) | d_msb;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // serial datapath: load on accept, shift one bit per busy cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            r_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (busy) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_nx;
            br    <= br_nx;
            cnt   <= cnt + CW'(1);
        end
    end

    // visible results change only on the last processing edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
        end else if (last) begin
            diff     <= r_nx;
            bout     <= br_nx;
            overflow <= (a_msb != b_msb) && (r_nx[WIDTH-1] != a_msb);
        end
    end

endmodule
